// File: rtl/addac_result_buffer.sv
// Result FIFO behind the ADDAC datapath: buffers {cout, s} entries for a slower sink,
// counts carry-out results (saturating) and flags drops caused by a full FIFO.
module addac_result_buffer #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_cout,
    input  logic [DATA_W-1:0]        in_s,
    input  logic                     rd_en,
    input  logic                     clr_flags,
    output logic                     out_valid,
    output logic                     out_cout,
    output logic [DATA_W-1:0]        out_s,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         carry_cnt,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [EW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              out_valid_q, out_valid_d;
    logic              out_cout_q, out_cout_d;
    logic [DATA_W-1:0] out_s_q, out_s_d;
    logic [CNT_W-1:0]  carry_cnt_q, carry_cnt_d;
    logic              overflow_q, overflow_d;

    logic full_s, empty_s, wr_acc_s, rd_acc_s, drop_s;
    logic [EW-1:0] head_s;

    assign full_s   = (level_q == LW'(DEPTH));
    assign empty_s  = (level_q == {LW{1'b0}});
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign wr_acc_s = in_valid && (!full_s || rd_en);
    assign rd_acc_s = rd_en && !empty_s;
    assign drop_s   = in_valid && full_s && !rd_en;
    assign head_s   = mem_q[rd_ptr_q];

    // Next-state logic for pointers, occupancy, read-out register and flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_valid_d = rd_acc_s;
        out_cout_d  = out_cout_q;
        out_s_d     = out_s_q;
        carry_cnt_d = carry_cnt_q;
        overflow_d  = overflow_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            out_cout_d = head_s[EW-1];
            out_s_d    = head_s[DATA_W-1:0];
        end else begin
            rd_ptr_d   = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Clear takes priority over holding, but a same-cycle carry write still counts.
        if (clr_flags) begin
            carry_cnt_d = (wr_acc_s && in_cout) ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (wr_acc_s && in_cout && (carry_cnt_q != CNT_MAX)) begin
            carry_cnt_d = carry_cnt_q + CNT_W'(1);
        end else begin
            carry_cnt_d = carry_cnt_q;
        end

        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_flags) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            level_q     <= {LW{1'b0}};
            out_valid_q <= 1'b0;
            out_cout_q  <= 1'b0;
            out_s_q     <= {DATA_W{1'b0}};
            carry_cnt_q <= {CNT_W{1'b0}};
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            out_cout_q  <= out_cout_d;
            out_s_q     <= out_s_d;
            carry_cnt_q <= carry_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // Entry storage; stale contents are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= {in_cout, in_s};
        end
    end

    assign out_valid = out_valid_q;
    assign out_cout  = out_cout_q;
    assign out_s     = out_s_q;
    assign full      = full_s;
    assign empty     = empty_s;
    assign level     = level_q;
    assign carry_cnt = carry_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/addac_result_buffer.md
Name: addac_result_buffer

Overview:
- Downstream stage of the ADDAC datapath. Captures each valid ADDAC result ({cout, s}) into a small synchronous FIFO so the consumer can drain results at its own rate.
- Keeps a saturating count of accepted results that carried out (cout=1).
- Keeps a sticky overflow flag for results dropped because the FIFO was full.
- Sits between the addac output and the result sink (display/logging logic).

Parameters:
- DATA_W, 4, width of the ADDAC sum s.
- DEPTH, 8, FIFO entries; must be a power of two ≥ 2.
- CNT_W, 8, width of carry_cnt.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ADDAC result present this cycle.
- in_cout  in  1  ADDAC carry-out.
- in_s  in  DATA_W  ADDAC sum.
- rd_en  in  1  consumer requests the head entry.
- clr_flags  in  1  synchronous clear of carry_cnt and overflow; FIFO contents are untouched.
- out_valid  out  1  out_cout/out_s hold a popped entry this cycle.
- out_cout  out  1  popped carry bit.
- out_s  out  DATA_W  popped sum.
- full  out  1  occupancy == DEPTH.
- empty  out  1  occupancy == 0.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- carry_cnt  out  CNT_W  count of accepted entries with cout=1.
- overflow  out  1  sticky: a write was dropped while full.

Behaviour:
- Reset (async assert, released synchronously to clk by the surrounding design):
  - pointers=0, level=0, empty=1, full=0.
  - out_valid=0, out_cout=0, out_s=0.
  - carry_cnt=0, overflow=0.
  - Reset mid-stream discards all stored entries immediately; no out_valid after release until a new write then read.
- Storage: entry = {cout, s}, DATA_W+1 bits. Read pointer, write pointer and level are registered. full, empty and level are derived from registered state and are valid in the same cycle.
- Write accepted when in_valid && (!full || rd_en):
  - entry is stored at the write pointer; write pointer increments modulo DEPTH (wrap from DEPTH-1 to 0).
- Read accepted when rd_en && !empty:
  - entry at the read pointer is registered into out_cout/out_s; out_valid=1 on the next cycle (one-cycle read latency).
  - Read pointer increments modulo DEPTH.
- Any cycle without an accepted read: out_valid=0. out_cout/out_s hold their last value.
- rd_en while empty: ignored; out_valid=0 next cycle; no pointer change.
- Simultaneous read and write:
  - When full: both accepted; level stays DEPTH; overflow not set.
  - When empty: write accepted, read ignored (no bypass); level becomes 1; out_valid=0 next cycle.
  - Otherwise: both accepted; level unchanged.
- Level update: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Overflow: in_valid && full && !rd_en → entry dropped; overflow←1 next cycle. It stays set until clr_flags or rst.
- carry_cnt: +1 on each accepted write with in_cout=1. Saturates at 2^CNT_W-1 and never wraps. Dropped writes are not counted.
- clr_flags:
  - carry_cnt←0 and overflow←0 on the next edge.
  - If an accepted carry write occurs in the same cycle, carry_cnt←1.
  - If a drop occurs in the same cycle, overflow←1 (the set wins).
- No combinational path from in_* to out_*.

Test Plan:
1. Reset then idle → empty=1, full=0, level=0, out_valid=0, carry_cnt=0, overflow=0. Assert rst mid-stream with level=5 → all of these immediately return to reset values.
2. Write {0,4'h3},{1,4'hA},{0,4'hF} on consecutive cycles, then rd_en for 3 cycles:
   - out_valid high for 3 cycles, starting one cycle after the first rd_en.
   - Outputs {0,3},{1,A},{0,F} in order.
   - carry_cnt=1; level returns to 0.
3. Fill with 8 writes → full=1, level=8. A 9th write without rd_en → dropped; overflow=1. Drain 8 entries → first 8 values in order. Pulse clr_flags → overflow=0, carry_cnt=0.
4. Full FIFO with in_valid and rd_en together for 4 cycles:
   - level stays 8, overflow stays 0.
   - Popped data is the oldest entries.
   - Write pointer wraps past 7 to 0 with data intact on a subsequent drain.
5. Empty FIFO, in_valid and rd_en together with {1,4'h5} → level=1, out_valid=0. Next rd_en → out_valid=1, out_s=5, out_cout=1.
6. With CNT_W=4, perform 20 accepted writes with in_cout=1 → carry_cnt saturates at 15 and does not wrap. clr_flags plus a carry write in the same cycle → carry_cnt=1.
